gb80_bus_controller: RTL and testbench

- Sits between gb80_processor and external memory (ROM/WRAM/IO).
- Converts single-byte read/write requests from the processor's address/data path into a Game Boy–style 4-T-state machine cycle on the memory bus.
- Supports memory wait states and a wait-timeout; returns read data / completion over a valid-only response channel.

---
 rtl/gb80_pkg.sv | 24 ++
 rtl/gb80_wait_counter.sv | 29 ++
 rtl/gb80_bus_controller.sv | 127 ++++++++++++
 tb/tb_gb80_bus_controller.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/gb80_pkg.sv
// Shared encodings for the gb80 memory bus controller: machine-cycle states,
// open-bus default and bus opcode constants.
package gb80_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_T1   = 3'd1;
  localparam logic [2:0] ST_T2   = 3'd2;
  localparam logic [2:0] ST_T3   = 3'd3;
  localparam logic [2:0] ST_T4   = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    T1   = ST_T1,
    T2   = ST_T2,
    T3   = ST_T3,
    T4   = ST_T4
  } bus_state_e;

  localparam logic [7:0] OPEN_BUS_DEF = 8'hFF;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/gb80_wait_counter.sv
// Saturating wait-state counter; terminal count flags MAX_WAIT waits taken.
module gb80_wait_counter #(
  parameter int MAX_WAIT = 15
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clr)
      count_d = '0;
    else if (i_en && !o_tc)
      count_d = count_q + 8'd1;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) count_q <= '0;
    else          count_q <= count_d;
  end

  assign o_tc = (count_q == 8'(MAX_WAIT));

endmodule

// File: rtl/gb80_bus_controller.sv
// Turns single-byte processor requests into a 4-T-state memory machine cycle
// with wait-state stretching in T3 and an open-bus timeout.
module gb80_bus_controller
  import gb80_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    MAX_WAIT   = 15,
  parameter logic [DATA_WIDTH-1:0] OPEN_BUS   = OPEN_BUS_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_error,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_rd,
  output logic                  o_mem_wr,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_ready
);

  bus_state_e state_q, state_d;

  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_lat_q, wdata_lat_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;

  logic accept, wait_tc, wait_en, timeout;

  assign o_req_ready = (state_q == IDLE) || (state_q == T4);
  assign accept      = i_req_valid && o_req_ready;
  assign timeout     = (state_q == T3) && !i_mem_ready && wait_tc;
  assign wait_en     = (state_q == T3) && !i_mem_ready;

  gb80_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (state_d == T1),
    .i_en    (wait_en),
    .o_tc    (wait_tc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? T1 : IDLE;
      T1:      state_d = T2;
      T2:      state_d = T3;
      T3:      state_d = (i_mem_ready || wait_tc) ? T4 : T3;
      T4:      state_d = accept ? T1 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // T-state they belong to; the address only ever moves on entry to T1.
  always_comb begin
    we_d        = we_q;
    wdata_lat_d = wdata_lat_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    if (accept) begin
      we_d        = i_req_we;
      wdata_lat_d = i_req_wdata;
      mem_addr_d  = i_req_addr;
    end
    if (state_d == T2 && we_q == OP_WRITE)
      mem_wdata_d = wdata_lat_q;
    if (state_q == T3 && we_q == OP_READ) begin
      if (i_mem_ready)  rsp_rdata_d = i_mem_rdata;
      else if (wait_tc) rsp_rdata_d = OPEN_BUS;
    end
    mem_rd_d    = (we_q == OP_READ)  && (state_d == T2 || state_d == T3);
    mem_wr_d    = (we_q == OP_WRITE) && (state_d == T2 || state_d == T3);
    rsp_valid_d = (state_d == T4);
    rsp_error_d = (state_d == T4) && timeout;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      we_q        <= OP_READ;
      wdata_lat_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      wdata_lat_q <= wdata_lat_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_rd    = mem_rd_q;
  assign o_mem_wr    = mem_wr_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_error = rsp_error_q;

endmodule

// File: tb/tb_gb80_bus_controller.sv
// Directed bench for gb80_bus_controller: reset, read/write latency, wait
// states, timeout, back-to-back accesses and mid-cycle reset.
module tb_gb80_bus_controller;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [15:0] i_req_addr;
  logic [7:0]  i_req_wdata;
  logic        o_rsp_valid;
  logic [7:0]  o_rsp_rdata;
  logic        o_rsp_error;
  logic [15:0] o_mem_addr;
  logic [7:0]  o_mem_wdata;
  logic        o_mem_rd;
  logic        o_mem_wr;
  logic [7:0]  i_mem_rdata;
  logic        i_mem_ready;

  int vectors = 0;
  int miscompares = 0;

  always #5 i_clk = ~i_clk;

  gb80_bus_controller dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_we    (i_req_we),
    .i_req_addr  (i_req_addr),
    .i_req_wdata (i_req_wdata),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_error (o_rsp_error),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_rd    (o_mem_rd),
    .o_mem_wr    (o_mem_wr),
    .i_mem_rdata (i_mem_rdata),
    .i_mem_ready (i_mem_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  // One access from IDLE; memory goes ready `waits` cycles into T3.
  // Reports cycles from accept to rsp_valid (0 if none within budget).
  task automatic do_access(input logic we, input logic [15:0] addr,
                           input logic [7:0] wdata, input logic [7:0] rdata,
                           input int waits, output int lat,
                           output int rd_cnt, output int wr_cnt);
    lat = 0; rd_cnt = 0; wr_cnt = 0;
    i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr; i_req_wdata = wdata;
    i_mem_rdata = rdata; i_mem_ready = 1'b0;
    tick();
    i_req_valid = 1'b0;
    for (int k = 1; k < 40; k++) begin
      i_mem_ready = (k >= 3 + waits);
      if (o_rsp_valid) begin
        lat = k;
        break;
      end
      if (o_mem_rd) rd_cnt++;
      if (o_mem_wr) wr_cnt++;
      tick();
    end
    i_mem_ready = 1'b0;
  endtask

  initial begin
    int lat, rdc, wrc;
    int acc_cyc[3];
    int rsp_cyc[3];
    logic [15:0] t1_addr[3];
    logic [15:0] addrs[3];
    int ai, ri, seen;

    // Reset with random inputs
    i_reset = 1'b0;
    i_req_valid = 1'($urandom); i_req_we = 1'($urandom);
    i_req_addr = 16'($urandom); i_req_wdata = 8'($urandom);
    i_mem_rdata = 8'($urandom); i_mem_ready = 1'($urandom);
    repeat (3) tick();
    chk("rst_outputs", {o_rsp_valid, o_rsp_error, o_mem_rd, o_mem_wr, o_rsp_rdata}, 32'h0);
    chk("rst_addr_wdata", {o_mem_addr, o_mem_wdata}, 32'h0);
    chk("rst_ready", o_req_ready, 1);
    i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = '0; i_req_wdata = '0;
    i_mem_rdata = '0; i_mem_ready = 1'b0;
    i_reset = 1'b1;
    tick();

    // Zero-wait read
    do_access(1'b0, 16'hC000, 8'h00, 8'h5A, 0, lat, rdc, wrc);
    chk("rd0_latency", lat, 4);
    chk("rd0_rd_cycles", rdc, 2);
    chk("rd0_wr_cycles", wrc, 0);
    chk("rd0_rdata", o_rsp_rdata, 8'h5A);
    chk("rd0_error", o_rsp_error, 0);
    chk("rd0_addr", o_mem_addr, 16'hC000);
    chk("rd0_t4_strobes", {o_mem_rd, o_mem_wr}, 0);
    tick();
    chk("rd0_pulse_width", o_rsp_valid, 0);

    // Write with three wait states; rdata must keep the last read value
    do_access(1'b1, 16'hFF40, 8'h3C, 8'hA5, 3, lat, rdc, wrc);
    chk("wr3_latency", lat, 7);
    chk("wr3_wr_cycles", wrc, 5);
    chk("wr3_rd_cycles", rdc, 0);
    chk("wr3_wdata", o_mem_wdata, 8'h3C);
    chk("wr3_addr", o_mem_addr, 16'hFF40);
    chk("wr3_rdata_kept", o_rsp_rdata, 8'h5A);
    chk("wr3_error", o_rsp_error, 0);
    tick();

    // Timeout: memory never ready
    do_access(1'b0, 16'h8000, 8'h00, 8'h12, 1000, lat, rdc, wrc);
    chk("to_latency", lat, 19);
    chk("to_rd_cycles", rdc, 17);
    chk("to_rdata_openbus", o_rsp_rdata, 8'hFF);
    chk("to_error", o_rsp_error, 1);
    tick();
    chk("to_error_clear", {o_rsp_valid, o_rsp_error}, 0);

    // Back-to-back reads with valid held
    addrs[0] = 16'h0100; addrs[1] = 16'h0101; addrs[2] = 16'h0102;
    ai = 0; ri = 0;
    i_mem_ready = 1'b1; i_mem_rdata = 8'h77; i_req_we = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (o_rsp_valid && ri < 3) begin rsp_cyc[ri] = c; ri++; end
      if (ai > 0 && c == acc_cyc[ai-1] + 1) t1_addr[ai-1] = o_mem_addr;
      i_req_valid = (ai < 3);
      i_req_addr  = (ai < 3) ? addrs[ai] : 16'h0;
      if (ai < 3 && o_req_ready) begin acc_cyc[ai] = c; ai++; end
      tick();
    end
    i_req_valid = 1'b0; i_mem_ready = 1'b0;
    chk("b2b_accepts", ai, 3);
    chk("b2b_rsp_count", ri, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_accept_cyc%0d", i), acc_cyc[i], 4 * i);
      chk($sformatf("b2b_rsp_cyc%0d", i), rsp_cyc[i], 4 * i + 4);
      chk($sformatf("b2b_t1_addr%0d", i), t1_addr[i], addrs[i]);
    end

    // Idle gap: back in IDLE, strobes low, address held
    chk("idle_ready", o_req_ready, 1);
    chk("idle_strobes", {o_mem_rd, o_mem_wr, o_rsp_valid}, 0);
    chk("idle_addr_hold", o_mem_addr, 16'h0102);

    // Reset asserted during T2 of a read
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 16'h4000;
    tick();
    i_req_valid = 1'b0;
    tick();
    chk("mid_rst_t2_rd", o_mem_rd, 1);
    #2 i_reset = 1'b0;
    #1 chk("mid_rst_rd_drop", o_mem_rd, 0);
    tick();
    i_reset = 1'b1;
    i_mem_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (o_rsp_valid) seen++;
      tick();
    end
    chk("mid_rst_no_rsp", seen, 0);
    chk("mid_rst_ready", o_req_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
